decode_stage_pipelined: RTL and testbench

//  Second-generation decode stage: splits a 32-bit MIPS instruction into fields, generates control,

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mips_regfile.sv | 39 +++
 rtl/decode_stage_pipelined.sv | 160 ++++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: opcodes, ALU-op encodings,
// FSM states and the per-instruction control bundle with its decoder.
package mips_pkg;

   localparam int ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_END   = 6'h3F;

   typedef enum logic [1:0] {
      ALU_RTYPE  = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_ADD    = 2'b11
   } alu_op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } dec_state_e;

   typedef struct packed {
      logic    reg_dest;
      logic    branch;
      logic    branch_ne;
      logic    mem_read;
      logic    mem_to_reg;
      logic    mem_write;
      logic    alu_src;
      logic    reg_write;
      logic    is_end;
      logic    illegal;
      logic    rt_used;
      alu_op_e alu_op;
   } ctrl_t;

   // Every field starts from zero so nothing leaks between instructions.
   function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
      ctrl_t c;
      c = '0;
      c.alu_op = ALU_RTYPE;
      case (opcode)
         OP_RTYPE: begin c.reg_dest = 1'b1; c.reg_write = 1'b1; c.rt_used = 1'b1; end
         OP_LW:    begin c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                         c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_SW:    begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.rt_used = 1'b1;
                         c.alu_op = ALU_ADD; end
         OP_BEQ:   begin c.branch = 1'b1; c.rt_used = 1'b1; c.alu_op = ALU_BRANCH; end
         OP_BNE:   begin c.branch = 1'b1; c.branch_ne = 1'b1; c.rt_used = 1'b1;
                         c.alu_op = ALU_BRANCH; end
         OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_END:   c.is_end = 1'b1;
         default:  c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// NUM_REGS x DATA_W register file, two combinational reads, one write port.
// Register 0 and out-of-range addresses read as zero; a same-cycle write bypasses to the reads.
module mips_regfile #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        raddr1,
   input  logic [4:0]        raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] regs [1:NUM_REGS-1];

   // Writes to r0 or beyond NUM_REGS match no entry and are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (wb_en && wb_addr == 5'(i)) regs[i] <= wb_data;
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (raddr1 == 5'(i)) rdata1 = (wb_en && wb_addr == 5'(i)) ? wb_data : regs[i];
         if (raddr2 == 5'(i)) rdata2 = (wb_en && wb_addr == 5'(i)) ? wb_data : regs[i];
      end
   end

endmodule

// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: field split, control decode, register read, busy-bit
// scoreboard with stall, halt FSM and a one-entry valid/ready output register.
module decode_stage_pipelined
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_opcode,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_funct,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_rdata1,
   output logic [DATA_W-1:0] out_rdata2,
   output logic [4:0]        out_wreg,
   output logic              out_reg_dest,
   output logic              out_branch,
   output logic              out_branch_ne,
   output logic              out_mem_read,
   output logic              out_mem_to_reg,
   output logic              out_mem_write,
   output logic              out_alu_src,
   output logic              out_reg_write,
   output logic              out_end,
   output logic              out_illegal,
   output logic [1:0]        out_alu_op,
   output logic              halted
);

   // Handshake: a transfer happens on a cycle where valid and ready are both high;
   // out_* stays stable while out_valid is high and out_ready is low.
   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd, wreg;
   logic [DATA_W-1:0] imm, rdata1, rdata2;
   ctrl_t             ctrl;
   logic [NUM_REGS-1:0] busy_q, busy_d, clr;
   logic              rs_busy, rt_busy, stall, accept;
   dec_state_e        state_q, state_d;

   assign opcode = in_instr[31:26];
   assign rs     = in_instr[25:21];
   assign rt     = in_instr[20:16];
   assign rd     = in_instr[15:11];
   assign ctrl   = decode_ctrl(opcode);
   assign wreg   = ctrl.reg_dest ? rd : rt;
   assign imm    = (opcode == OP_RTYPE) ? '0 : DATA_W'($signed(in_instr[15:0]));

   mips_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .raddr1  (rs),
      .raddr2  (rt),
      .rdata1  (rdata1),
      .rdata2  (rdata2),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   // A register being written back this cycle is no longer a hazard; a new set wins over a clear.
   always_comb begin
      clr     = '0;
      busy_d  = '0;
      rs_busy = 1'b0;
      rt_busy = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         clr[i] = wb_en && (wb_addr == 5'(i));
         if (rs == 5'(i)) rs_busy = busy_q[i] && !clr[i];
         if (rt == 5'(i)) rt_busy = busy_q[i] && !clr[i];
         busy_d[i] = (busy_q[i] && !clr[i]) ||
                     (accept && ctrl.reg_write && i != 0 && wreg == 5'(i));
      end
   end

   assign stall    = !(ctrl.is_end || ctrl.illegal) && (rs_busy || (ctrl.rt_used && rt_busy));
   assign in_ready = (state_q == ST_RUN) && !stall && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign halted   = (state_q == ST_HALT);

   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN && accept && ctrl.is_end) state_d = ST_HALT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid      <= 1'b0;
         out_opcode     <= '0;
         out_rs         <= '0;
         out_rt         <= '0;
         out_rd         <= '0;
         out_shamt      <= '0;
         out_funct      <= '0;
         out_imm        <= '0;
         out_rdata1     <= '0;
         out_rdata2     <= '0;
         out_wreg       <= '0;
         out_reg_dest   <= 1'b0;
         out_branch     <= 1'b0;
         out_branch_ne  <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_to_reg <= 1'b0;
         out_mem_write  <= 1'b0;
         out_alu_src    <= 1'b0;
         out_reg_write  <= 1'b0;
         out_end        <= 1'b0;
         out_illegal    <= 1'b0;
         out_alu_op     <= '0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_opcode     <= opcode;
         out_rs         <= rs;
         out_rt         <= rt;
         out_rd         <= rd;
         out_shamt      <= in_instr[10:6];
         out_funct      <= in_instr[5:0];
         out_imm        <= imm;
         out_rdata1     <= rdata1;
         out_rdata2     <= rdata2;
         out_wreg       <= wreg;
         out_reg_dest   <= ctrl.reg_dest;
         out_branch     <= ctrl.branch;
         out_branch_ne  <= ctrl.branch_ne;
         out_mem_read   <= ctrl.mem_read;
         out_mem_to_reg <= ctrl.mem_to_reg;
         out_mem_write  <= ctrl.mem_write;
         out_alu_src    <= ctrl.alu_src;
         out_reg_write  <= ctrl.reg_write;
         out_end        <= ctrl.is_end;
         out_illegal    <= ctrl.illegal;
         out_alu_op     <= ctrl.alu_op;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed scenarios plus randomized traffic
// checked against an instruction-level reference model of the stage.
module tb_decode_stage_pipelined;

   localparam int BW = 145;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
   logic [31:0] in_instr = '0, wb_data = '0;
   logic [4:0]  wb_addr = '0;
   logic        in_ready, out_valid, halted;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt, out_wreg;
   logic [31:0] out_imm, out_rdata1, out_rdata2;
   logic        out_reg_dest, out_branch, out_branch_ne, out_mem_read, out_mem_to_reg;
   logic        out_mem_write, out_alu_src, out_reg_write, out_end, out_illegal;
   logic [1:0]  out_alu_op;

   logic        in_valid_b = 1'b0, out_ready_b = 1'b0, wb_en_b = 1'b0;
   logic [31:0] in_instr_b = '0, wb_data_b = '0;
   logic [4:0]  wb_addr_b = '0;
   logic        in_ready_b, out_valid_b, halted_b;
   logic [5:0]  out_opcode_b, out_funct_b;
   logic [4:0]  out_rs_b, out_rt_b, out_rd_b, out_shamt_b, out_wreg_b;
   logic [31:0] out_imm_b, out_rdata1_b, out_rdata2_b;
   logic        out_reg_dest_b, out_branch_b, out_branch_ne_b, out_mem_read_b, out_mem_to_reg_b;
   logic        out_mem_write_b, out_alu_src_b, out_reg_write_b, out_end_b, out_illegal_b;
   logic [1:0]  out_alu_op_b;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0]   m_regs [32];
   logic          m_busy [32];
   logic          m_halt;
   logic [BW-1:0] exp_q [$];

   always #5 clk = ~clk;

   decode_stage_pipelined #(.DATA_W(32), .NUM_REGS(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
      .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
      .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_wreg(out_wreg),
      .out_reg_dest(out_reg_dest), .out_branch(out_branch), .out_branch_ne(out_branch_ne),
      .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
      .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
      .out_end(out_end), .out_illegal(out_illegal), .out_alu_op(out_alu_op), .halted(halted)
   );

   decode_stage_pipelined #(.DATA_W(32), .NUM_REGS(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_instr(in_instr_b), .wb_en(wb_en_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_opcode(out_opcode_b),
      .out_rs(out_rs_b), .out_rt(out_rt_b), .out_rd(out_rd_b), .out_shamt(out_shamt_b),
      .out_funct(out_funct_b), .out_imm(out_imm_b), .out_rdata1(out_rdata1_b),
      .out_rdata2(out_rdata2_b), .out_wreg(out_wreg_b), .out_reg_dest(out_reg_dest_b),
      .out_branch(out_branch_b), .out_branch_ne(out_branch_ne_b),
      .out_mem_read(out_mem_read_b), .out_mem_to_reg(out_mem_to_reg_b),
      .out_mem_write(out_mem_write_b), .out_alu_src(out_alu_src_b),
      .out_reg_write(out_reg_write_b), .out_end(out_end_b), .out_illegal(out_illegal_b),
      .out_alu_op(out_alu_op_b), .halted(halted_b)
   );

   function automatic logic [BW-1:0] dut_bundle();
      return {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm, out_rdata1,
              out_rdata2, out_wreg, out_reg_dest, out_branch, out_branch_ne, out_mem_read,
              out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_end, out_illegal,
              out_alu_op};
   endfunction

   // {reg_dest,branch,branch_ne,mem_read,mem_to_reg,mem_write,alu_src,reg_write,end,illegal, alu_op}
   function automatic logic [11:0] model_ctl(input logic [5:0] op);
      case (op)
         6'h00:   return {10'b1000000100, 2'b00};
         6'h23:   return {10'b0001101100, 2'b11};
         6'h2B:   return {10'b0000011000, 2'b11};
         6'h04:   return {10'b0100000000, 2'b01};
         6'h05:   return {10'b0110000000, 2'b01};
         6'h08:   return {10'b0000001100, 2'b11};
         6'h3F:   return {10'b0000000010, 2'b00};
         default: return {10'b0000000001, 2'b00};
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic [BW-1:0] model_bundle(input logic [31:0] ins);
      logic [11:0] c;
      logic [31:0] imm;
      logic [4:0]  wr;
      c   = model_ctl(ins[31:26]);
      imm = (ins[31:26] == 6'h00) ? 32'd0 : {{16{ins[15]}}, ins[15:0]};
      wr  = c[11] ? ins[15:11] : ins[20:16];
      return {ins, imm, model_read(ins[25:21]), model_read(ins[20:16]), wr, c};
   endfunction

   function automatic logic model_ready();
      logic [5:0] op;
      logic       rt_used, hz;
      op = in_instr[31:26];
      rt_used = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
      hz = (m_busy[in_instr[25:21]] && !(wb_en && wb_addr == in_instr[25:21])) ||
           (rt_used && m_busy[in_instr[20:16]] && !(wb_en && wb_addr == in_instr[20:16]));
      if (model_ctl(op)[3] || model_ctl(op)[2]) hz = 1'b0;
      return !m_halt && !hz && (exp_q.size() == 0 || out_ready);
   endfunction

   // Advance the model by one clock using the inputs currently driven, then step the clock.
   task automatic cycle();
      logic          acc;
      logic [BW-1:0] b;
      logic [11:0]   c;
      logic [4:0]    wr;
      if (reset) begin
         for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
         m_halt = 1'b0;
         exp_q.delete();
      end else begin
         acc = in_valid && model_ready();
         b   = model_bundle(in_instr);
         c   = model_ctl(in_instr[31:26]);
         wr  = c[11] ? in_instr[15:11] : in_instr[20:16];
         if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(b);
         if (wb_en) m_busy[wb_addr] = 1'b0;
         if (acc && c[4] && wr != 0) m_busy[wr] = 1'b1;
         if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
         if (acc && c[3]) m_halt = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
      do_reset();
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_chk++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
      n_chk++; if (dut_bundle() !== '0) begin n_err++; $display("FAIL reset_fields got %h want 0", dut_bundle()); end
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_chk++; if (out_valid_b !== 1'b0) begin n_err++; $display("FAIL reset_out_valid16 got %b want 0", out_valid_b); end
   endtask

   task automatic test_r_add();
      wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'd5; cycle();
      wb_addr = 5'd9; wb_data = 32'd7; cycle();
      wb_en = 1'b0;
      in_valid = 1'b1; in_instr = 32'h01095020; out_ready = 1'b1;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL radd_in_ready got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL radd_out_valid got %b want 1", out_valid); end
      n_chk++; if (out_rdata1 !== 32'd5 || out_rdata2 !== 32'd7)
         begin n_err++; $display("FAIL radd_rdata got %0d,%0d want 5,7", out_rdata1, out_rdata2); end
      n_chk++; if (out_wreg !== 5'd10 || out_reg_dest !== 1'b1 || out_alu_op !== 2'b00)
         begin n_err++; $display("FAIL radd_ctrl got wreg=%0d rd=%b op=%b want 10,1,00", out_wreg, out_reg_dest, out_alu_op); end
      n_chk++; if (exp_q.size() == 0 || dut_bundle() !== exp_q[0])
         begin n_err++; $display("FAIL radd_bundle got %h", dut_bundle()); end
   endtask

   task automatic test_lw_stall();
      in_valid = 1'b1; in_instr = 32'h8D09FFFC; out_ready = 1'b1;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lw_in_ready got %b want 1", in_ready); end
      cycle();
      n_chk++; if (out_imm !== 32'hFFFFFFFC || out_mem_read !== 1'b1 || out_wreg !== 5'd9)
         begin n_err++; $display("FAIL lw_fields got imm=%h mr=%b wreg=%0d want fffffffc,1,9", out_imm, out_mem_read, out_wreg); end
      in_instr = 32'h01095020;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lw_stall cyc%0d in_ready got %b want 0", k, in_ready); end
         cycle();
      end
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd3;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lw_release in_ready got %b want 1", in_ready); end
      cycle();
      wb_en = 1'b0; in_valid = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b1 || out_rdata2 !== 32'd3)
         begin n_err++; $display("FAIL lw_bypass got v=%b rdata2=%0d want 1,3", out_valid, out_rdata2); end
      n_chk++; if (exp_q.size() == 0 || dut_bundle() !== exp_q[0])
         begin n_err++; $display("FAIL lw_bundle got %h", dut_bundle()); end
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] snap;
      out_ready = 1'b1; cycle();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h200B0001;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
      cycle();
      snap = dut_bundle();
      in_instr = 32'h10000004;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL bp_hold cyc%0d got ready=%b valid=%b want 0,1", k, in_ready, out_valid); end
         n_chk++; if (exp_q.size() == 0 || dut_bundle() !== exp_q[0] || dut_bundle() !== snap)
            begin n_err++; $display("FAIL bp_stable cyc%0d got %h", k, dut_bundle()); end
         cycle();
      end
      out_ready = 1'b1;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b1 || out_opcode !== 6'h04 || exp_q.size() != 1 || dut_bundle() !== exp_q[0])
         begin n_err++; $display("FAIL bp_next got v=%b op=%h want 1,04", out_valid, out_opcode); end
      cycle();
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
   endtask

   task automatic test_regfile_edges();
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF; cycle();
      wb_en = 1'b0; in_valid = 1'b1; in_instr = 32'h00000820; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1 || out_rdata1 !== 32'd0 || out_rdata2 !== 32'd0)
         begin n_err++; $display("FAIL r0_read got v=%b %h,%h want 1,0,0", out_valid, out_rdata1, out_rdata2); end
      n_chk++; if (exp_q.size() == 0 || dut_bundle() !== exp_q[0])
         begin n_err++; $display("FAIL r0_bundle got %h", dut_bundle()); end
      wb_en_b = 1'b1; wb_addr_b = 5'd20; wb_data_b = 32'hAB; cycle();
      wb_addr_b = 5'd8; wb_data_b = 32'h55; cycle();
      wb_en_b = 1'b0; in_valid_b = 1'b1; in_instr_b = 32'h02880000; out_ready_b = 1'b1;
      #1;
      n_chk++; if (in_ready_b !== 1'b1) begin n_err++; $display("FAIL n16_ready got %b want 1", in_ready_b); end
      cycle();
      in_valid_b = 1'b0;
      n_chk++; if (out_valid_b !== 1'b1 || out_rdata1_b !== 32'd0 || out_rdata2_b !== 32'h55)
         begin n_err++; $display("FAIL n16_read got v=%b r20=%h r8=%h want 1,0,55", out_valid_b, out_rdata1_b, out_rdata2_b); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h080C0000;
      cycle();
      n_chk++; if (out_illegal !== 1'b1 || exp_q.size() == 0 || dut_bundle() !== exp_q[0])
         begin n_err++; $display("FAIL illegal_bundle got ill=%b %h", out_illegal, dut_bundle()); end
      in_instr = 32'hAC0C0000;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_nobusy got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0;
      n_chk++; if (out_mem_write !== 1'b1 || exp_q.size() == 0 || dut_bundle() !== exp_q[0])
         begin n_err++; $display("FAIL sw_bundle got %h", dut_bundle()); end
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      logic [5:0] op;
      int         busy_list [$];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h00};
      for (int c = 0; c < 400; c++) begin
         op = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 62));
         in_instr = {op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                     5'($urandom_range(0, 15)), 5'($urandom), 6'($urandom)};
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         busy_list.delete();
         for (int i = 0; i < 32; i++) if (m_busy[i]) busy_list.push_back(i);
         wb_en   = ($urandom_range(0, 1) != 0);
         wb_addr = (busy_list.size() != 0 && $urandom_range(0, 2) != 0) ?
                   5'(busy_list[$urandom_range(0, busy_list.size() - 1)]) : 5'($urandom_range(0, 15));
         wb_data = $urandom;
         #1;
         n_chk++; if (in_ready !== model_ready())
            begin n_err++; $display("FAIL rand_ready cyc%0d got %b want %b", c, in_ready, model_ready()); end
         n_chk++; if (out_valid !== (exp_q.size() != 0))
            begin n_err++; $display("FAIL rand_valid cyc%0d got %b want %b", c, out_valid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            n_chk++; if (dut_bundle() !== exp_q[0])
               begin n_err++; $display("FAIL rand_bundle cyc%0d got %h want %h", c, dut_bundle(), exp_q[0]); end
         end
         cycle();
      end
      in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_halt();
      do_reset();
      in_valid = 1'b1; in_instr = 32'hFC000000; out_ready = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL halt_end_ready got %b want 1", in_ready); end
      cycle();
      in_instr = 32'h20010001;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++; if (halted !== 1'b1 || in_ready !== 1'b0 || out_end !== 1'b1)
            begin n_err++; $display("FAIL halt_state cyc%0d got h=%b rdy=%b end=%b want 1,0,1", k, halted, in_ready, out_end); end
         out_ready = (k == 2);
         cycle();
      end
      #1;
      n_chk++; if (out_valid !== 1'b0 || halted !== 1'b1)
         begin n_err++; $display("FAIL halt_drain got v=%b h=%b want 0,1", out_valid, halted); end
      reset = 1'b1; out_ready = 1'b1;
      cycle();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      n_chk++; if (halted !== 1'b0 || out_valid !== 1'b0)
         begin n_err++; $display("FAIL halt_reset got h=%b v=%b want 0,0", halted, out_valid); end
   endtask

   task automatic test_reset_pending();
      in_valid = 1'b1; in_instr = 32'h200B0001; out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstp_pending got %b want 1", out_valid); end
      reset = 1'b1; out_ready = 1'b1;
      cycle();
      reset = 1'b0;
      n_chk++; if (out_valid !== 1'b0 || dut_bundle() !== '0)
         begin n_err++; $display("FAIL rstp_discard got v=%b %h want 0,0", out_valid, dut_bundle()); end
   endtask

   initial begin
      test_reset();
      test_r_add();
      test_lw_stall();
      test_backpressure();
      test_regfile_edges();
      test_illegal();
      test_random();
      test_halt();
      test_reset_pending();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
